// File: rtl/trash_pkg.sv
// rtl/trash_pkg.sv - shared constants, FSM state enum and character helpers for the worksheet loader
package trash_pkg;

    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_STAR = 8'h2A;
    localparam logic [7:0] ASCII_PLUS = 8'h2B;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_ADD = 1'b1;

    localparam int NUM_ELEMENTS = 1000;
    localparam int DATA_WIDTH   = 16;
    localparam int NUM_ROWS     = 4;

    typedef enum logic [1:0] {
        ROW_FILL = 2'd0,
        OP_SCAN  = 2'd1,
        FLUSH    = 2'd2,
        DONE     = 2'd3
    } loader_state_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_ZERO) && (c <= ASCII_ZERO + 8'd9);
    endfunction

    // Anything that is not a digit lands as 0, so spaces and stray characters both read as blanks.
    function automatic logic [3:0] char_nibble(input logic [7:0] c);
        return is_digit(c) ? c[3:0] : 4'h0;
    endfunction

endpackage

// File: rtl/worksheet_row_buf.sv
// rtl/worksheet_row_buf.sv - one digit row: MAX_COLS x 4-bit store, one write port, one synchronous read port
module worksheet_row_buf #(
    parameter int MAX_COLS = 4096,
    parameter int AW       = $clog2(MAX_COLS)
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [3:0]    wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [3:0]    rd_data_o
);

    logic [3:0] mem_q [MAX_COLS];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/trash_worksheet_loader.sv
// rtl/trash_worksheet_loader.sv - parses a 5-row ASCII worksheet into packed problem writes; LOADER_CHECK_EN enables err
module trash_worksheet_loader #(
    parameter int MAX_COLS     = 4096,
    parameter int NUM_ELEMENTS = trash_pkg::NUM_ELEMENTS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     data_in,
    input  logic                           valid_in,
    output logic                           ready,
    output logic                           wr_en,
    output logic [9:0]                     wr_addr,
    output logic [trash_pkg::DATA_WIDTH-1:0] wr_line1,
    output logic [trash_pkg::DATA_WIDTH-1:0] wr_line2,
    output logic [trash_pkg::DATA_WIDTH-1:0] wr_line3,
    output logic [trash_pkg::DATA_WIDTH-1:0] wr_line4,
    output logic                           wr_op,
    output logic [10:0]                    count,
    output logic                           done,
    output logic                           err
);
    import trash_pkg::*;

    localparam int AW = $clog2(MAX_COLS);
    localparam int XW = $clog2(MAX_COLS + 1);

    loader_state_e         state_q;
    logic [1:0]            row_q;
    logic [XW-1:0]         x_q;
    logic [XW-1:0]         len_q [NUM_ROWS];
    logic                  ready_q, done_q;
    logic                  wr_en_q, wr_op_q;
    logic [9:0]            wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_line_q [NUM_ROWS];
    logic [10:0]           count_q;

    // Read-issue stage: one entry describing the op-row character whose buffer read is in flight.
    logic                  pend_q, pend_is_op_q, pend_op_q;
    logic [NUM_ROWS-1:0]   pend_mask_q;

    logic                  open_q, open_d;
    logic [2:0]            col_q, col_d;
    logic                  op_q, op_d;
    logic [DATA_WIDTH-1:0] acc_q [NUM_ROWS];
    logic [DATA_WIDTH-1:0] acc_d [NUM_ROWS];
    logic [3:0]            nib_base;
    logic                  close, wr_fire;

    logic                  accept, is_lf, is_op_ch, in_range, rd_en;
    logic [NUM_ROWS-1:0]   buf_we;
    logic [3:0]            buf_rdata [NUM_ROWS];
    logic [3:0]            merged [NUM_ROWS];
    logic [3:0]            nib_in;

    assign accept   = valid_in && ready_q;
    assign is_lf    = (data_in == ASCII_LF);
    assign is_op_ch = (data_in == ASCII_STAR) || (data_in == ASCII_PLUS);
    assign in_range = (x_q < XW'(MAX_COLS));
    assign rd_en    = (state_q == OP_SCAN) && accept && !is_lf && in_range;
    assign nib_in   = char_nibble(data_in);

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        assign buf_we[r] = (state_q == ROW_FILL) && accept && !is_lf && in_range && (row_q == 2'(r));
        assign merged[r] = pend_mask_q[r] ? buf_rdata[r] : 4'h0;

        worksheet_row_buf #(
            .MAX_COLS (MAX_COLS),
            .AW       (AW)
        ) u_buf (
            .clk_i     (clk),
            .wr_en_i   (buf_we[r]),
            .wr_addr_i (x_q[AW-1:0]),
            .wr_data_i (nib_in),
            .rd_en_i   (rd_en),
            .rd_addr_i (x_q[AW-1:0]),
            .rd_data_o (buf_rdata[r])
        );
    end

    // The closing write always takes acc_q, so an op landing on the same cycle starts from fresh nibbles.
    always_comb begin
        acc_d    = acc_q;
        col_d    = col_q;
        open_d   = open_q;
        op_d     = op_q;
        close    = 1'b0;
        nib_base = {col_q[1:0] + 2'd1, 2'b00};
        if (pend_q) begin
            if (pend_is_op_q) begin
                close  = open_q;
                open_d = 1'b1;
                col_d  = 3'd0;
                op_d   = pend_op_q;
                for (int r = 0; r < NUM_ROWS; r++) begin
                    acc_d[r] = {12'h000, merged[r]};
                end
            end else if (open_q) begin
                if (col_q < 3'd3) begin
                    col_d = col_q + 3'd1;
                    for (int r = 0; r < NUM_ROWS; r++) begin
                        acc_d[r][nib_base +: 4] = merged[r];
                    end
                end else begin
                    col_d = 3'd4;
                end
            end
        end else if ((state_q == FLUSH) && open_q) begin
            close  = 1'b1;
            open_d = 1'b0;
        end
    end

    assign wr_fire = close && (count_q < 11'(NUM_ELEMENTS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ROW_FILL;
            row_q        <= 2'd0;
            x_q          <= '0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 10'd0;
            wr_op_q      <= 1'b0;
            count_q      <= 11'd0;
            pend_q       <= 1'b0;
            pend_is_op_q <= 1'b0;
            pend_op_q    <= 1'b0;
            pend_mask_q  <= '0;
            open_q       <= 1'b0;
            col_q        <= 3'd0;
            op_q         <= 1'b0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                len_q[r]     <= '0;
                acc_q[r]     <= '0;
                wr_line_q[r] <= '0;
            end
        end else begin
            wr_en_q      <= 1'b0;
            pend_q       <= rd_en;
            pend_is_op_q <= is_op_ch;
            pend_op_q    <= (data_in == ASCII_PLUS) ? OP_ADD : OP_MUL;
            for (int r = 0; r < NUM_ROWS; r++) begin
                pend_mask_q[r] <= (x_q < len_q[r]);
                acc_q[r]       <= acc_d[r];
            end
            col_q  <= col_d;
            open_q <= open_d;
            op_q   <= op_d;

            if (wr_fire) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= count_q[9:0];
                wr_op_q   <= op_q;
                count_q   <= count_q + 11'd1;
                for (int r = 0; r < NUM_ROWS; r++) begin
                    wr_line_q[r] <= acc_q[r];
                end
            end

            case (state_q)
                ROW_FILL: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (is_lf) begin
                            len_q[row_q] <= x_q;
                            x_q          <= '0;
                            row_q        <= row_q + 2'd1;
                            if (row_q == 2'd3) begin
                                state_q <= OP_SCAN;
                            end
                        end else if (in_range) begin
                            x_q <= x_q + XW'(1);
                        end
                    end
                end
                OP_SCAN: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (is_lf) begin
                            state_q <= FLUSH;
                            ready_q <= 1'b0;
                        end else if (in_range) begin
                            x_q <= x_q + XW'(1);
                        end
                    end
                end
                FLUSH: begin
                    ready_q <= 1'b0;
                    if (!pend_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

`ifdef LOADER_CHECK_EN
    logic [XW-1:0] max_len;
    logic          is_sp, row_hit, op_hit, col_hit, cnt_hit, err_hit, err_q;

    always_comb begin
        max_len = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (len_q[r] > max_len) begin
                max_len = len_q[r];
            end
        end
    end

    assign is_sp   = (data_in == ASCII_SP);
    assign row_hit = (state_q == ROW_FILL) && accept && !is_lf &&
                     (!in_range || !(is_digit(data_in) || is_sp));
    assign op_hit  = (state_q == OP_SCAN) && accept && !is_lf &&
                     (!in_range || !(is_op_ch || is_sp) || (x_q >= max_len));
    assign col_hit = pend_q && !pend_is_op_q && open_q && (col_q >= 3'd3);
    assign cnt_hit = close && !wr_fire;
    assign err_hit = row_hit || op_hit || col_hit || cnt_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign ready    = ready_q;
    assign done     = done_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_op    = wr_op_q;
    assign count    = count_q;
    assign wr_line1 = wr_line_q[0];
    assign wr_line2 = wr_line_q[1];
    assign wr_line3 = wr_line_q[2];
    assign wr_line4 = wr_line_q[3];

endmodule

// File: tb/tb_trash_worksheet_loader.sv
// tb/tb_trash_worksheet_loader.sv - self-checking bench: directed vector table, reset sequences, random streams vs model
module tb_trash_worksheet_loader;

    localparam int MAXC = 24;
    localparam int NEL  = 5;
`ifdef LOADER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        valid_in = 1'b0;
    logic        ready, wr_en, wr_op, done, err;
    logic [9:0]  wr_addr;
    logic [15:0] wr_line1, wr_line2, wr_line3, wr_line4;
    logic [10:0] count;

    always #5 clk = ~clk;

    trash_worksheet_loader #(
        .MAX_COLS     (MAXC),
        .NUM_ELEMENTS (NEL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready    (ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_line1 (wr_line1),
        .wr_line2 (wr_line2),
        .wr_line3 (wr_line3),
        .wr_line4 (wr_line4),
        .wr_op    (wr_op),
        .count    (count),
        .done     (done),
        .err      (err)
    );

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] l1;
        logic [15:0] l2;
        logic [15:0] l3;
        logic [15:0] l4;
        logic        op;
    } wr_t;

    typedef struct {
        string s;
        int    gmin;
        int    gmax;
        int    cnt;
        bit    e;
        int    nw;
        wr_t   w0;
        wr_t   w1;
    } vec_t;

    wr_t  got_q[$];
    wr_t  exp_q[$];
    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            got_q.push_back({wr_addr, wr_line1, wr_line2, wr_line3, wr_line4, wr_op});
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic wr_t mkw(input int a, input logic [15:0] l1, input logic [15:0] l2,
                                input logic [15:0] l3, input logic [15:0] l4, input logic op);
        return {10'(a), l1, l2, l3, l4, op};
    endfunction

    task automatic add_vec(input string s, input int gmin, input int gmax, input int cnt,
                           input bit e, input int nw, input wr_t w0, input wr_t w1);
        vec_t v;
        v.s = s; v.gmin = gmin; v.gmax = gmax; v.cnt = cnt;
        v.e = e; v.nw = nw; v.w0 = w0; v.w1 = w1;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        data_in  = 8'h00;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got_q.delete();
    endtask

    task automatic send_char(input byte c);
        int n = 0;
        data_in  = c;
        valid_in = 1'b1;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: char %0h not accepted within 20 cycles", c);
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic send_stream(input string s, input int gmin, input int gmax);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
            if (gmax > 0) repeat ($urandom_range(gmax, gmin)) @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_result(input string tag, input int exp_cnt, input bit exp_err);
        chk({tag, " nwrites"}, 128'(got_q.size()), 128'(exp_cnt));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s write%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
        end
        chk({tag, " count"}, 128'(count), 128'(exp_cnt));
        chk({tag, " done"},  128'(done), 128'(1));
        chk({tag, " err"},   128'(err), 128'(exp_err));
        chk({tag, " ready"}, 128'(ready), 128'(0));
    endtask

    // Reference model: splits the stream into rows and walks the op row column by column.
    byte         mrow[5][$];
    int          mlen[4];
    int          m_cnt;
    bit          m_err;
    logic [15:0] m_ln[4];
    logic        m_op;

    function automatic logic [3:0] nibm(input int k, input int p);
        byte c;
        if (p < mlen[k]) begin
            c = mrow[k][p];
            if (c >= 48 && c <= 57) return 4'(c - 48);
        end
        return 4'h0;
    endfunction

    task automatic m_close();
        if (m_cnt < NEL) begin
            exp_q.push_back({10'(m_cnt), m_ln[0], m_ln[1], m_ln[2], m_ln[3], m_op});
            m_cnt++;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic model(input string s);
        int  r = 0, col = 0, maxl = 0;
        bit  open = 1'b0;
        byte c;
        exp_q.delete();
        m_cnt = 0;
        m_err = 1'b0;
        for (int k = 0; k < 5; k++) mrow[k].delete();
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == 8'h0A) r++;
            else if (r < 5) mrow[r].push_back(c);
        end
        for (int k = 0; k < 4; k++) begin
            mlen[k] = (mrow[k].size() < MAXC) ? mrow[k].size() : MAXC;
            if (mlen[k] > maxl) maxl = mlen[k];
            for (int p = 0; p < mrow[k].size(); p++) begin
                c = mrow[k][p];
                if (p >= MAXC) m_err = 1'b1;
                else if (!((c >= 48 && c <= 57) || c == 8'h20)) m_err = 1'b1;
            end
        end
        for (int p = 0; p < mrow[4].size(); p++) begin
            if (p >= MAXC) begin
                m_err = 1'b1;
                continue;
            end
            if (p >= maxl) m_err = 1'b1;
            c = mrow[4][p];
            if (c == 8'h2A || c == 8'h2B) begin
                if (open) m_close();
                open = 1'b1;
                col  = 0;
                m_op = (c == 8'h2B);
                for (int k = 0; k < 4; k++) m_ln[k] = {12'h000, nibm(k, p)};
            end else begin
                if (c != 8'h20) m_err = 1'b1;
                if (open) begin
                    col++;
                    if (col <= 3) begin
                        for (int k = 0; k < 4; k++) m_ln[k][4*col +: 4] = nibm(k, p);
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
        if (open) m_close();
    endtask

    function automatic string gen_stream();
        string s = "";
        int    n, k;
        byte   c;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(MAXC + 2, 0);
            for (int j = 0; j < n; j++) begin
                k = $urandom_range(99, 0);
                if (k < 78)      c = byte'(48 + $urandom_range(9, 0));
                else if (k < 95) c = 8'h20;
                else             c = 8'h78;
                s = $sformatf("%s%c", s, c);
            end
            s = {s, "\n"};
        end
        n = $urandom_range(MAXC + 2, 0);
        for (int j = 0; j < n; j++) begin
            k = $urandom_range(99, 0);
            if (k < 18)      c = 8'h2A;
            else if (k < 36) c = 8'h2B;
            else if (k < 96) c = 8'h20;
            else             c = 8'h3F;
            s = $sformatf("%s%c", s, c);
        end
        return {s, "\n"};
    endfunction

    string base_s;
    string long_row;
    string long_op;
    string rs;

    initial begin
        base_s   = "12 \n3 4\n5  \n678\n* +\n";
        long_row = "1234567890123456789012345\n";
        long_op  = "";
        for (int i = 0; i < 22; i++) long_op = {long_op, " "};
        long_op = {long_op, "* +\n"};

        add_vec(base_s, 0, 0, 2, 1'b0, 2,
                mkw(0, 16'h0021, 16'h0003, 16'h0005, 16'h0076, 1'b0),
                mkw(1, 16'h0000, 16'h0004, 16'h0000, 16'h0008, 1'b1));
        add_vec(base_s, 1, 1, 2, 1'b0, 2,
                mkw(0, 16'h0021, 16'h0003, 16'h0005, 16'h0076, 1'b0),
                mkw(1, 16'h0000, 16'h0004, 16'h0000, 16'h0008, 1'b1));
        add_vec("1234\n5678\n9012\n3456\n  * \n", 0, 0, 1, 1'b0, 1,
                mkw(0, 16'h0043, 16'h0087, 16'h0021, 16'h0065, 1'b0), '0);
        add_vec("12 \n3x4\n5  \n678\n* +\n", 0, 0, 2, 1'b1, 2,
                mkw(0, 16'h0021, 16'h0003, 16'h0005, 16'h0076, 1'b0),
                mkw(1, 16'h0000, 16'h0004, 16'h0000, 16'h0008, 1'b1));
        add_vec("12345\n12345\n12345\n12345\n*    \n", 0, 0, 1, 1'b1, 1,
                mkw(0, 16'h4321, 16'h4321, 16'h4321, 16'h4321, 1'b0), '0);
        add_vec("9\n8\n7\n6\n+\n", 0, 0, 1, 1'b0, 1,
                mkw(0, 16'h0009, 16'h0008, 16'h0007, 16'h0006, 1'b1), '0);
        add_vec("1234567\n2345678\n3456789\n4567890\n*+*+*+*\n", 0, 0, NEL, 1'b1, 2,
                mkw(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0),
                mkw(1, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 1'b1));
        add_vec("1\n2\n3\n4\n* \n", 0, 0, 1, 1'b1, 1,
                mkw(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0), '0);
        add_vec({long_row, long_row, long_row, long_row, long_op}, 0, 0, 1, 1'b1, 1,
                mkw(0, 16'h0043, 16'h0043, 16'h0043, 16'h0043, 1'b0), '0);

        // Reset state while rst_n is held low, then first-edge ready rise.
        @(negedge clk);
        chk("rst ready", 128'(ready), 128'(0));
        chk("rst wr_en", 128'(wr_en), 128'(0));
        chk("rst count", 128'(count), 128'(0));
        chk("rst done",  128'(done), 128'(0));
        chk("rst err",   128'(err), 128'(0));
        chk("rst wr fields", 128'({wr_addr, wr_line1, wr_line2, wr_line3, wr_line4, wr_op}), 128'(0));
        rst_n = 1'b1;
        #1;
        chk("ready before first edge", 128'(ready), 128'(0));
        @(negedge clk);
        chk("ready after first edge", 128'(ready), 128'(1));

        for (int i = 0; i < vecs.size(); i++) begin
            do_reset();
            exp_q.delete();
            if (vecs[i].nw > 0) exp_q.push_back(vecs[i].w0);
            if (vecs[i].nw > 1) exp_q.push_back(vecs[i].w1);
            send_stream(vecs[i].s, vecs[i].gmin, vecs[i].gmax);
            wait_done();
            check_result($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].e & CHK);
        end

        // Done is sticky and further input is ignored; then an asynchronous reset clears everything.
        do_reset();
        send_stream(base_s, 0, 0);
        wait_done();
        data_in  = 8'h2A;
        valid_in = 1'b1;
        repeat (8) @(negedge clk);
        valid_in = 1'b0;
        chk("sticky nwrites", 128'(got_q.size()), 128'(2));
        chk("sticky done",    128'(done), 128'(1));
        chk("sticky ready",   128'(ready), 128'(0));
        chk("sticky count",   128'(count), 128'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("async rst done",  128'(done), 128'(0));
        chk("async rst count", 128'(count), 128'(0));
        chk("async rst lines", 128'({wr_line1, wr_line2, wr_line3, wr_line4, wr_op}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Reset after three rows discards the partial load.
        do_reset();
        send_stream("99 \n9 9\n999\n", 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midload rst ready", 128'(ready), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(vecs[0].w0);
        exp_q.push_back(vecs[0].w1);
        send_stream(base_s, 0, 0);
        wait_done();
        check_result("midload", 2, 1'b0);

        for (int t = 0; t < 20; t++) begin
            do_reset();
            rs = gen_stream();
            model(rs);
            send_stream(rs, 0, 2);
            wait_done();
            check_result($sformatf("rand%0d", t), exp_q.size(), m_err & CHK);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trash_worksheet_loader.md
TRASH_WORKSHEET_LOADER -- requirements
Module: trash_worksheet_loader

Interface
REQ-001 SHALL take parameter MAX_COLS, default 4096: maximum characters per input row.
REQ-002 SHALL take parameter NUM_ELEMENTS, default 1000: maximum problems; write address space.
REQ-003 SHALL have ports, in this order:
- clk  in  1  clock.
- rst_n  in  1  reset.
- data_in  in  8  ASCII character.
- valid_in  in  1  character valid.
- ready  out  1  character accepted when valid_in&&ready.
- wr_en  out  1  one-cycle problem write strobe.
- wr_addr  out  10  problem index.
- wr_line1..wr_line4  out  16 each  packed digit words for rows 1-4.
- wr_op  out  1  0=multiply, 1=add.
- count  out  11  problems written.
- done  out  1  load complete, sticky.
- err  out  1  sticky error.
REQ-004 SHALL use one clock, clk; rst_n is asynchronous and active-low.

Function
REQ-005 Input SHALL be 5 rows, row-major, each terminated by 0x0A: rows 1-4 hold digits/spaces, row 5 holds '*', '+', spaces.
REQ-006 FSM states SHALL be ROW_FILL, OP_SCAN, FLUSH, DONE; reset enters ROW_FILL with row=0 and x=0.
REQ-007 ROW_FILL SHALL write nibble (digit '0'-'9' -> 0-9, space -> 0) at position x of row buffer [row], then increment x.
- On 0x0A: store len[row]=x; x=0; row++.
- After the 4th newline: go to OP_SCAN.
REQ-008 A row-buffer read at position x>=len[row] SHALL return 0.
REQ-009 In OP_SCAN, accepting a character at position x SHALL issue a synchronous read of all four buffers at x; data SHALL be merged one cycle later.
REQ-010 An op character SHALL close any open problem and open a new one: col=0, op latched ('*'->0, '+'->1).
- A space SHALL advance col within the open problem.
- Spaces before the first op SHALL be ignored.
REQ-011 Merged nibble of row r SHALL go to wr_line(r+1)[4*col+3:4*col]: col 0 = leftmost column = bits[3:0]; row 1 = most significant digit.
REQ-012 Closing a problem SHALL pulse wr_en for one cycle with wr_addr=count, then increment count.
REQ-013 Newline in OP_SCAN SHALL enter FLUSH with ready=0.
- FLUSH closes the open problem (if any) after the pending merge, then goes to DONE.
REQ-014 DONE SHALL hold done=1, ready=0, wr_en=0 until reset.
REQ-015 ready SHALL be 1 in ROW_FILL and OP_SCAN, and 0 in FLUSH and DONE.
REQ-016 Boundary conditions:
- A character at x>=MAX_COLS SHALL be dropped.
- A column beyond col 3 SHALL be discarded.
- A problem beyond NUM_ELEMENTS SHALL not be written (count saturates at NUM_ELEMENTS).
- Each of these SHALL set err when LOADER_CHECK_EN is defined.
REQ-017 A write and a new op on the same cycle SHALL both take effect: the closing write uses old data, and the new problem starts with zeroed nibbles.

Reset
REQ-018 Assertion of rst_n=0 at any time SHALL give:
- wr_en=0, wr_addr=0, wr_line1..4=0, wr_op=0, count=0, done=0, err=0, ready=0.
- all len[]=0, FSM=ROW_FILL.
- Buffer contents need not be cleared.
REQ-019 ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-020 Reset mid-load SHALL discard the partial load; a full new input stream is then required.

Configuration
REQ-021 With macro LOADER_CHECK_EN defined, err SHALL be set on each of the following:
- a row-1..4 character outside digits/space/0x0A;
- an op-row character outside '*'/'+'/space/0x0A;
- the REQ-016 overflows;
- row-5 length exceeding max(len[]).
REQ-022 Without LOADER_CHECK_EN, err SHALL be tied 0 and illegal characters SHALL be treated as space.

Structure
REQ-023 Shared package trash_pkg SHALL hold: ASCII constants (0x0A, 0x20, 0x2A, 0x2B, 0x30), OP_MUL=0 / OP_ADD=1, NUM_ELEMENTS, DATA_WIDTH=16, and the FSM state enum.
REQ-024 Sub-module worksheet_row_buf SHALL be instantiated 4 times: MAX_COLS x 4 bits, 1 write port, 1 synchronous read port.

Verification
REQ-025 Stream "12 \n3 4\n5  \n678\n* +\n" -> two writes:
- addr0: line1..4 = 0x0021, 0x0003, 0x0005, 0x0076; op=0.
- addr1: line1..4 = 0x0000, 0x0004, 0x0000, 0x0008; op=1.
- then count=2, done=1, err=0.
REQ-026 Same stream with valid_in toggled every other cycle -> identical writes and count.
REQ-027 rst_n pulsed low after the third row, then the full REQ-025 stream -> only the REQ-025 writes; count=2.
REQ-028 Op row "  * \n" with 4-char digit rows -> one write at addr0 (leading spaces ignored); count=1.
REQ-029 With LOADER_CHECK_EN: 'x' in row 2 -> err=1, load still completes, done=1; without the macro -> err=0 and the 'x' is written as nibble 0.
REQ-030 Problem of width 5 ("*    \n") -> 5th column dropped; err=1 only with LOADER_CHECK_EN.
